filter_tap_sender: RTL and testbench

//  Transmit side of the filter tap-setting message protocol.

---
 rtl/filter_tap_sender_pkg.sv | 26 ++
 rtl/filter_tap_sender_buffer.sv | 26 ++
 rtl/filter_tap_sender.sv | 147 ++++++++++++++
 tb/tb_filter_tap_sender.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/filter_tap_sender_pkg.sv
// Shared message-bus definitions for the filter tap-setting protocol.
// Used by the tap sender and by the filter that consumes its messages.
package filter_tap_sender_pkg;

    // Message word layout: [flag | target id | length] for headers,
    // [0 | sign-extended tap] for payload words.
    localparam int MSG_WIDTH    = 32;
    localparam int MSG_FLAG_BIT = MSG_WIDTH - 1;
    localparam int MSG_ID_W     = 8;
    localparam int MSG_ID_LSB   = MSG_FLAG_BIT - MSG_ID_W;
    localparam int MSG_LEN_W    = MSG_ID_LSB;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_SEND   = 2'd2
    } tx_state_e;

    function automatic logic [MSG_WIDTH-1:0] make_header(
        input logic [MSG_ID_W-1:0]  id,
        input logic [MSG_LEN_W-1:0] len
    );
        return {1'b1, id, len};
    endfunction

endpackage

// File: rtl/filter_tap_sender_buffer.sv
// Local tap store: one synchronous write port, one registered read port.
// Contents are deliberately not reset; the host rewrites taps as needed.
module filter_tap_buffer #(
    parameter int TWIDTH     = 16,
    parameter int LENGTH     = 8,
    parameter int LOG_LENGTH = 3
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [LOG_LENGTH-1:0] wr_addr,
    input  logic [TWIDTH-1:0]     wr_data,
    input  logic [LOG_LENGTH-1:0] rd_addr,
    output logic [TWIDTH-1:0]     rd_data
);

    logic [TWIDTH-1:0] mem [LENGTH];

    // Write when enabled; read data appears one cycle after the address.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/filter_tap_sender.sv
// Transmit side of the tap-setting protocol: sends header + LENGTH taps on
// start, otherwise forwards upstream bus traffic so senders can be chained.
module filter_tap_sender
    import filter_tap_sender_pkg::*;
#(
    parameter int TWIDTH     = 16,
    parameter int LENGTH     = 8,
    parameter int LOG_LENGTH = 3,
    parameter int TARGET_ID  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tap_wr_en,
    input  logic [LOG_LENGTH-1:0] tap_wr_addr,
    input  logic [TWIDTH-1:0]     tap_wr_data,
    input  logic                  start,
    input  logic [MSG_WIDTH-1:0]  in_msg,
    input  logic                  in_msg_nd,
    output logic [MSG_WIDTH-1:0]  out_msg,
    output logic                  out_msg_nd,
    output logic                  busy,
    output logic                  error
);

    localparam logic [LOG_LENGTH:0]  LAST_CNT    = (LOG_LENGTH + 1)'(LENGTH);
    localparam logic [MSG_WIDTH-1:0] HEADER_WORD =
        make_header(MSG_ID_W'(TARGET_ID), MSG_LEN_W'(LENGTH));

    tx_state_e               state_q, state_d;
    logic [LOG_LENGTH:0]     cnt_q, cnt_d;
    logic [MSG_WIDTH-1:0]    out_msg_q, out_msg_d;
    logic                    out_nd_q, out_nd_d;
    logic                    error_q, error_d;
    logic [LOG_LENGTH-1:0]   rd_addr;
    logic [TWIDTH-1:0]       rd_data;
    logic                    wr_addr_ok;

    function automatic logic [MSG_WIDTH-1:0] tap_word(input logic signed [TWIDTH-1:0] tap);
        logic signed [MSG_WIDTH-2:0] ext;
        ext = (MSG_WIDTH - 1)'(tap);
        return {1'b0, ext};
    endfunction

    // Indices past the end only occur on the final prefetch; park them at 0.
    function automatic logic [LOG_LENGTH-1:0] next_addr(input logic [LOG_LENGTH:0] idx);
        return (idx < LAST_CNT) ? idx[LOG_LENGTH-1:0] : '0;
    endfunction

    assign wr_addr_ok = int'(tap_wr_addr) < LENGTH;

    filter_tap_buffer #(
        .TWIDTH    (TWIDTH),
        .LENGTH    (LENGTH),
        .LOG_LENGTH(LOG_LENGTH)
    ) u_buffer (
        .clk    (clk),
        .wr_en  (tap_wr_en && wr_addr_ok),
        .wr_addr(tap_wr_addr),
        .wr_data(tap_wr_data),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    // State, counter, registered output word and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            out_msg_q <= '0;
            out_nd_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_msg_q <= out_msg_d;
            out_nd_q  <= out_nd_d;
            error_q   <= error_d;
        end
    end

    // Next-state, output mux and error detection. cnt_q is the index of the
    // tap currently on rd_data; the read address always runs one ahead.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_msg_d = '0;
        out_nd_d  = 1'b0;
        error_d   = error_q;
        rd_addr   = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_HEADER;
                    cnt_d     = '0;
                    out_msg_d = HEADER_WORD;
                    out_nd_d  = 1'b1;
                    if (in_msg_nd) error_d = 1'b1;
                end else begin
                    out_msg_d = in_msg;
                    out_nd_d  = in_msg_nd;
                end
            end
            ST_HEADER: begin
                state_d   = ST_SEND;
                cnt_d     = (LOG_LENGTH + 1)'(1);
                out_msg_d = tap_word(rd_data);
                out_nd_d  = 1'b1;
                rd_addr   = next_addr((LOG_LENGTH + 1)'(1));
                if (start || in_msg_nd) error_d = 1'b1;
            end
            ST_SEND: begin
                if (in_msg_nd) error_d = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    // Last tap is on the bus; a new start chains straight on.
                    if (start) begin
                        state_d   = ST_HEADER;
                        cnt_d     = '0;
                        out_msg_d = HEADER_WORD;
                        out_nd_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    out_msg_d = tap_word(rd_data);
                    out_nd_d  = 1'b1;
                    rd_addr   = next_addr(cnt_q + 1'b1);
                    if (start) error_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (tap_wr_en && ((state_q != ST_IDLE) || !wr_addr_ok)) begin
            error_d = 1'b1;
        end
    end

    assign out_msg    = out_msg_q;
    assign out_msg_nd = out_nd_q;
    assign busy       = (state_q != ST_IDLE);
    assign error      = error_q;

endmodule

// File: tb/tb_filter_tap_sender.sv
// Directed bench for filter_tap_sender (LENGTH=8 instance plus a LENGTH=5
// instance for out-of-range write addresses).
module tb_filter_tap_sender;
    import filter_tap_sender_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 tap_wr_en;
    logic [2:0]           tap_wr_addr;
    logic [15:0]          tap_wr_data;
    logic                 start;
    logic [MSG_WIDTH-1:0] in_msg;
    logic                 in_msg_nd;
    logic [MSG_WIDTH-1:0] out_msg;
    logic                 out_msg_nd;
    logic                 busy;
    logic                 error;

    logic                 wr_en2;
    logic [2:0]           wr_addr2;
    logic [15:0]          wr_data2;
    logic                 start2;
    logic                 nd2;
    logic [MSG_WIDTH-1:0] out_msg2;
    logic                 out_nd2;
    logic                 busy2;
    logic                 error2;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] taps  [8] = '{16'h0001, 16'hFFFF, 16'h0002, 16'hFFFE,
                               16'h0003, 16'hFFFD, 16'h0004, 16'hFFFC};
    logic [31:0] exp_w [8] = '{32'h0000_0001, 32'h7FFF_FFFF, 32'h0000_0002, 32'h7FFF_FFFE,
                               32'h0000_0003, 32'h7FFF_FFFD, 32'h0000_0004, 32'h7FFF_FFFC};
    localparam logic [31:0] HDR  = 32'h8080_0008;
    localparam logic [31:0] HDR2 = 32'h8100_0005;

    filter_tap_sender #(.TWIDTH(16), .LENGTH(8), .LOG_LENGTH(3), .TARGET_ID(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .tap_wr_en(tap_wr_en), .tap_wr_addr(tap_wr_addr), .tap_wr_data(tap_wr_data),
        .start(start), .in_msg(in_msg), .in_msg_nd(in_msg_nd),
        .out_msg(out_msg), .out_msg_nd(out_msg_nd), .busy(busy), .error(error)
    );

    filter_tap_sender #(.TWIDTH(16), .LENGTH(5), .LOG_LENGTH(3), .TARGET_ID(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .tap_wr_en(wr_en2), .tap_wr_addr(wr_addr2), .tap_wr_data(wr_data2),
        .start(start2), .in_msg(in_msg), .in_msg_nd(nd2),
        .out_msg(out_msg2), .out_msg_nd(out_nd2), .busy(busy2), .error(error2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Called on the header cycle; walks through the taps and the idle cycle after.
    task automatic check_msg(input string tag);
        chk({tag, "_hdr_nd"}, 32'(out_msg_nd), 32'd1);
        chk({tag, "_hdr"}, out_msg, HDR);
        chk({tag, "_hdr_busy"}, 32'(busy), 32'd1);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("%s_tap%0d_nd", tag, k), 32'(out_msg_nd), 32'd1);
            chk($sformatf("%s_tap%0d", tag, k), out_msg, exp_w[k]);
            chk($sformatf("%s_tap%0d_busy", tag, k), 32'(busy), 32'd1);
        end
        tick();
        chk({tag, "_end_nd"}, 32'(out_msg_nd), 32'd0);
        chk({tag, "_end_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int nwords;
        int gaps;
        int leaked;

        rst_n = 1'b0; tap_wr_en = 0; tap_wr_addr = 0; tap_wr_data = 0;
        start = 0; in_msg = 0; in_msg_nd = 0;
        wr_en2 = 0; wr_addr2 = 0; wr_data2 = 0; start2 = 0; nd2 = 0;
        #2;
        chk("rst_out", out_msg, 32'h0);
        chk("rst_nd", 32'(out_msg_nd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // 1: basic message
        for (int i = 0; i < 8; i++) begin
            tap_wr_en = 1; tap_wr_addr = 3'(i); tap_wr_data = taps[i];
            tick();
        end
        tap_wr_en = 0;
        chk("t1_wr_err", 32'(error), 32'd0);
        start = 1; tick(); start = 0;
        check_msg("t1");
        chk("t1_err", 32'(error), 32'd0);

        // 2: idle pass-through
        in_msg = 32'h1234_5678; in_msg_nd = 1; tick();
        chk("t2_w0", out_msg, 32'h1234_5678);
        chk("t2_nd0", 32'(out_msg_nd), 32'd1);
        in_msg = 32'h9ABC_DEF0; tick();
        chk("t2_w1", out_msg, 32'h9ABC_DEF0);
        in_msg = 32'h0F0F_0F0F; tick();
        chk("t2_w2", out_msg, 32'h0F0F_0F0F);
        in_msg_nd = 0; tick();
        chk("t2_nd_off", 32'(out_msg_nd), 32'd0);
        chk("t2_err", 32'(error), 32'd0);

        // 3: start while busy is ignored
        do_reset();
        start = 1; tick(); start = 0;
        nwords = 0;
        for (int c = 1; c <= 14; c++) begin
            if (out_msg_nd) nwords++;
            if (c == 9) chk("t3_last_tap", out_msg, 32'h7FFF_FFFC);
            start = (c == 4);
            tick();
        end
        start = 0;
        chk("t3_words", 32'(nwords), 32'd9);
        chk("t3_err", 32'(error), 32'd1);

        // 4: back-to-back messages
        do_reset();
        start = 1; tick(); start = 0;
        nwords = 0; gaps = 0;
        for (int c = 1; c <= 20; c++) begin
            if (out_msg_nd) nwords++;
            else if (c <= 18) gaps++;
            if (c == 10) chk("t4_hdr2", out_msg, HDR);
            if (c == 18) chk("t4_last", out_msg, 32'h7FFF_FFFC);
            start = (c == 9);
            tick();
        end
        start = 0;
        chk("t4_words", 32'(nwords), 32'd18);
        chk("t4_gaps", 32'(gaps), 32'd0);
        chk("t4_err", 32'(error), 32'd0);

        // 5a: upstream word during a send is dropped
        do_reset();
        start = 1; tick(); start = 0;
        nwords = 0; leaked = 0;
        for (int c = 1; c <= 12; c++) begin
            if (out_msg_nd) nwords++;
            if (out_msg_nd && out_msg == 32'hDEAD_BEEF) leaked++;
            in_msg = 32'hDEAD_BEEF;
            in_msg_nd = (c == 3);
            tick();
        end
        in_msg_nd = 0;
        chk("t5a_words", 32'(nwords), 32'd9);
        chk("t5a_leak", 32'(leaked), 32'd0);
        chk("t5a_err", 32'(error), 32'd1);

        // 5b: start and upstream word together in idle: start wins
        do_reset();
        chk("t5b_err_clr", 32'(error), 32'd0);
        start = 1; in_msg = 32'hCAFE_F00D; in_msg_nd = 1; tick();
        start = 0; in_msg_nd = 0;
        chk("t5b_hdr", out_msg, HDR);
        chk("t5b_err", 32'(error), 32'd1);
        for (int c = 0; c < 9; c++) tick();

        // 5c: write address range on a LENGTH=5 instance
        do_reset();
        wr_en2 = 1; wr_addr2 = 3'd0; wr_data2 = 16'h8000; tick();
        wr_addr2 = 3'd4; wr_data2 = 16'h0005; tick();
        wr_en2 = 0;
        chk("t5c_ok_err", 32'(error2), 32'd0);
        start2 = 1; tick(); start2 = 0;
        chk("t5c_hdr", out_msg2, HDR2);
        tick();
        chk("t5c_tap0", out_msg2, 32'h7FFF_8000);
        for (int c = 0; c < 4; c++) tick();
        chk("t5c_tap4", out_msg2, 32'h0000_0005);
        chk("t5c_tap4_nd", 32'(out_nd2), 32'd1);
        tick();
        chk("t5c_end_nd", 32'(out_nd2), 32'd0);
        chk("t5c_err_pre", 32'(error2), 32'd0);
        wr_en2 = 1; wr_addr2 = 3'd6; wr_data2 = 16'h1111; tick();
        wr_en2 = 0;
        chk("t5c_oob_err", 32'(error2), 32'd1);

        // 6: reset in the middle of a send
        do_reset();
        start = 1; tick(); start = 0;
        for (int c = 0; c < 4; c++) tick();
        chk("t6_pre_nd", 32'(out_msg_nd), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_nd", 32'(out_msg_nd), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        in_msg = 32'h55AA_55AA; in_msg_nd = 1; tick();
        in_msg_nd = 0;
        chk("t6_pass", out_msg, 32'h55AA_55AA);
        chk("t6_pass_nd", 32'(out_msg_nd), 32'd1);
        tick();
        start = 1; tick(); start = 0;
        check_msg("t6");
        chk("t6_err", 32'(error), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
